// File: rtl/gen_arb4rr_pkg.sv
// Shared types and constants for the gen_arb4rr four-port round-robin arbiter.
package gen_arb4rr_pkg;

    localparam int                DATA_W        = 32;
    localparam int                ARB_NPORT     = 4;
    localparam logic [DATA_W-1:0] RDATA_TIMEOUT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_RESP,
        ST_RELEASE
    } arb_state_t;

endpackage

// File: rtl/gen_arb4rr_if.sv
// Requester-side and device-side bus bundle of gen_arb4rr.
interface gen_arb4rr_if;
    import gen_arb4rr_pkg::*;

    logic [DATA_W-1:0] p0_addr, p0_wdata, p0_rdata;
    logic [3:0]        p0_be;
    logic              p0_wr, p0_req, p0_ack;

    logic [DATA_W-1:0] p1_addr, p1_wdata, p1_rdata;
    logic [3:0]        p1_be;
    logic              p1_wr, p1_req, p1_ack;

    logic [DATA_W-1:0] p2_addr, p2_wdata, p2_rdata;
    logic [3:0]        p2_be;
    logic              p2_wr, p2_req, p2_ack;

    logic [DATA_W-1:0] p3_addr, p3_wdata, p3_rdata;
    logic [3:0]        p3_be;
    logic              p3_wr, p3_req, p3_ack;

    logic [DATA_W-1:0] dev_addr, dev_wdata, dev_rdata;
    logic [3:0]        dev_be;
    logic              dev_wr, dev_req, dev_ack;
    logic              to_err;

    // The arbiter side
    modport master (
        input  p0_addr, p0_wdata, p0_be, p0_wr, p0_req,
        input  p1_addr, p1_wdata, p1_be, p1_wr, p1_req,
        input  p2_addr, p2_wdata, p2_be, p2_wr, p2_req,
        input  p3_addr, p3_wdata, p3_be, p3_wr, p3_req,
        output p0_rdata, p0_ack, p1_rdata, p1_ack,
        output p2_rdata, p2_ack, p3_rdata, p3_ack,
        output dev_addr, dev_wdata, dev_be, dev_wr, dev_req,
        input  dev_rdata, dev_ack,
        output to_err
    );

    // Requesters plus device
    modport slave (
        output p0_addr, p0_wdata, p0_be, p0_wr, p0_req,
        output p1_addr, p1_wdata, p1_be, p1_wr, p1_req,
        output p2_addr, p2_wdata, p2_be, p2_wr, p2_req,
        output p3_addr, p3_wdata, p3_be, p3_wr, p3_req,
        input  p0_rdata, p0_ack, p1_rdata, p1_ack,
        input  p2_rdata, p2_ack, p3_rdata, p3_ack,
        input  dev_addr, dev_wdata, dev_be, dev_wr, dev_req,
        output dev_rdata, dev_ack,
        input  to_err
    );

endinterface

// File: rtl/gen_rr_pick4.sv
// Combinational 4-way round-robin picker: searches from last+1 upward, wrapping.
module gen_rr_pick4
    import gen_arb4rr_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] grant,
    output logic       valid
);

    logic [1:0] idx;

    always_comb begin
        grant = 2'd0;
        valid = 1'b0;
        idx   = 2'd0;
        // i == ARB_NPORT wraps back to last itself, so it has lowest priority
        for (int i = 1; i <= ARB_NPORT; i++) begin
            idx = last + 2'(i);
            if (!valid && req[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gen_arb4rr.sv
// Four-port round-robin arbiter in front of one shared device.
// Defining GEN_ARB4RR_TIMEOUT_EN adds a dev_ack timeout of TO_CYCLES cycles.
module gen_arb4rr
    import gen_arb4rr_pkg::*;
#(
    parameter int TO_CYCLES = 255
) (
    input  logic         dev_clk,
    input  logic         dev_rst_n,
    gen_arb4rr_if.master bus
);

    if (TO_CYCLES < 1 || TO_CYCLES > 65535) begin : g_to_range
        $error("gen_arb4rr: TO_CYCLES must be in 1..65535");
    end

    logic [ARB_NPORT-1:0] req_v;
    logic [ARB_NPORT-1:0] wr_v;
    logic [DATA_W-1:0]    addr_v  [ARB_NPORT];
    logic [DATA_W-1:0]    wdata_v [ARB_NPORT];
    logic [3:0]           be_v    [ARB_NPORT];

    assign req_v = {bus.p3_req, bus.p2_req, bus.p1_req, bus.p0_req};
    assign wr_v  = {bus.p3_wr,  bus.p2_wr,  bus.p1_wr,  bus.p0_wr};
    assign addr_v[0]  = bus.p0_addr;   assign addr_v[1]  = bus.p1_addr;
    assign addr_v[2]  = bus.p2_addr;   assign addr_v[3]  = bus.p3_addr;
    assign wdata_v[0] = bus.p0_wdata;  assign wdata_v[1] = bus.p1_wdata;
    assign wdata_v[2] = bus.p2_wdata;  assign wdata_v[3] = bus.p3_wdata;
    assign be_v[0]    = bus.p0_be;     assign be_v[1]    = bus.p1_be;
    assign be_v[2]    = bus.p2_be;     assign be_v[3]    = bus.p3_be;

    arb_state_t           state;
    logic [1:0]           last_grant;
    logic [1:0]           gnt;
    logic [1:0]           pick_idx;
    logic                 pick_vld;
    logic [DATA_W-1:0]    dev_addr_q, dev_wdata_q;
    logic [3:0]           dev_be_q;
    logic                 dev_wr_q, dev_req_q;
    logic [ARB_NPORT-1:0] ack_q;
    logic [DATA_W-1:0]    rdata_q [ARB_NPORT];

    gen_rr_pick4 u_pick (
        .req   (req_v),
        .last  (last_grant),
        .grant (pick_idx),
        .valid (pick_vld)
    );

`ifdef GEN_ARB4RR_TIMEOUT_EN
    // to_cnt counts GRANT cycles with dev_req already high
    localparam logic [15:0] TO_LAST = 16'(TO_CYCLES - 1);
    logic [15:0] to_cnt;
    logic        to_err_q;
    assign bus.to_err = to_err_q;
`else
    assign bus.to_err = 1'b0;
`endif

    always_ff @(posedge dev_clk or negedge dev_rst_n) begin
        if (!dev_rst_n) begin
            state       <= ST_IDLE;
            last_grant  <= 2'd3;
            gnt         <= 2'd0;
            dev_addr_q  <= '0;
            dev_wdata_q <= '0;
            dev_be_q    <= '0;
            dev_wr_q    <= 1'b0;
            dev_req_q   <= 1'b0;
            ack_q       <= '0;
            for (int i = 0; i < ARB_NPORT; i++) rdata_q[i] <= '0;
`ifdef GEN_ARB4RR_TIMEOUT_EN
            to_cnt      <= '0;
            to_err_q    <= 1'b0;
`endif
        end else begin
            ack_q <= '0;
`ifdef GEN_ARB4RR_TIMEOUT_EN
            to_err_q <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        gnt         <= pick_idx;
                        dev_addr_q  <= addr_v[pick_idx];
                        dev_wdata_q <= wdata_v[pick_idx];
                        dev_be_q    <= be_v[pick_idx];
                        dev_wr_q    <= wr_v[pick_idx];
                        state       <= ST_GRANT;
`ifdef GEN_ARB4RR_TIMEOUT_EN
                        to_cnt      <= '0;
`endif
                    end
                end
                ST_GRANT: begin
                    // A real dev_ack always beats a timeout in the same cycle
                    if (bus.dev_ack) begin
                        rdata_q[gnt] <= bus.dev_rdata;
                        ack_q[gnt]   <= 1'b1;
                        dev_req_q    <= 1'b0;
                        state        <= ST_RESP;
                    end
`ifdef GEN_ARB4RR_TIMEOUT_EN
                    else if (dev_req_q && to_cnt == TO_LAST) begin
                        rdata_q[gnt] <= RDATA_TIMEOUT;
                        ack_q[gnt]   <= 1'b1;
                        dev_req_q    <= 1'b0;
                        to_err_q     <= 1'b1;
                        state        <= ST_RESP;
                    end
`endif
                    else begin
                        dev_req_q <= 1'b1;
`ifdef GEN_ARB4RR_TIMEOUT_EN
                        if (dev_req_q) to_cnt <= to_cnt + 16'd1;
`endif
                    end
                end
                ST_RESP: begin
                    last_grant <= gnt;
                    state      <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!req_v[gnt]) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.dev_addr  = dev_addr_q;
    assign bus.dev_wdata = dev_wdata_q;
    assign bus.dev_be    = dev_be_q;
    assign bus.dev_wr    = dev_wr_q;
    assign bus.dev_req   = dev_req_q;

    assign bus.p0_ack   = ack_q[0];
    assign bus.p1_ack   = ack_q[1];
    assign bus.p2_ack   = ack_q[2];
    assign bus.p3_ack   = ack_q[3];
    assign bus.p0_rdata = rdata_q[0];
    assign bus.p1_rdata = rdata_q[1];
    assign bus.p2_rdata = rdata_q[2];
    assign bus.p3_rdata = rdata_q[3];

endmodule

// File: doc/gen_arb4rr.md
GEN_ARB4RR -- requirements
Module: gen_arb4rr

Interface
REQ-001 SHALL have parameter TO_CYCLES, default 255, giving the dev_ack timeout length in cycles (used only under GEN_ARB4RR_TIMEOUT_EN; legal range 1..65535).
REQ-002 SHALL have port dev_clk  in  1  single clock; all logic rising-edge.
REQ-003 SHALL have port dev_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports pN_addr, pN_wdata  in  32 each  requester address and write data, N=0..3.
REQ-005 SHALL have ports pN_be  in  4, pN_wr  in  1, pN_req  in  1  byte enables, write flag and level request, N=0..3.
REQ-006 SHALL have ports pN_rdata  out  32, pN_ack  out  1  registered read data and one-cycle acknowledge, N=0..3.
REQ-007 SHALL have ports dev_addr, dev_wdata  out  32, dev_be  out  4, dev_wr  out  1, dev_req  out  1  to the shared device.
REQ-008 SHALL have ports dev_rdata  in  32, dev_ack  in  1  device response.
REQ-009 SHALL have port to_err  out  1  one-cycle pulse on a device timeout.

Function
REQ-010 SHALL implement states IDLE, GRANT, RESP and RELEASE.
REQ-011 In IDLE with any pN_req sampled high, SHALL pick the winner round-robin, starting at (last_grant+1) mod 4, and enter GRANT.
REQ-012 On entry to GRANT, SHALL register the winner's addr, wdata, be and wr onto dev_*, and SHALL drive dev_req high from the next cycle.
REQ-013 SHALL hold dev_* stable and dev_req high in GRANT until dev_ack is sampled high.
REQ-014 When dev_ack is sampled high in cycle M, SHALL capture dev_rdata, drive dev_req low in M+1, and enter RESP.
REQ-015 In RESP, SHALL drive pN_ack of the granted port high for exactly one cycle (M+1), with pN_rdata already equal to the captured data.
REQ-016 SHALL update pN_rdata only on that port's own ack and hold it otherwise; writes also update pN_rdata.
REQ-017 SHALL set last_grant to the granted port in RESP.
REQ-018 In RELEASE, SHALL wait until the granted pN_req is sampled low, then return to IDLE; other ports' requests are only considered from IDLE.
REQ-019 Total latency SHALL be 2 cycles from pN_req sampled to dev_req high, plus 1 cycle from dev_ack sampled to pN_ack.
REQ-020 Requests from non-granted ports SHALL wait, and SHALL never be dropped or acked.
REQ-021 dev_ack seen outside GRANT SHALL be ignored.

Reset
REQ-022 With dev_rst_n low, SHALL force: state IDLE; last_grant=3 so port 0 wins first; all pN_ack, pN_rdata, dev_* and to_err = 0.
REQ-023 If reset is asserted mid-transaction, SHALL abort the transaction with no ack produced; after release, arbitration restarts from IDLE.

Configuration
REQ-024 With macro GEN_ARB4RR_TIMEOUT_EN defined, SHALL count cycles in GRANT.
REQ-025 Under GEN_ARB4RR_TIMEOUT_EN, when the count reaches TO_CYCLES without dev_ack, SHALL drop dev_req, pulse to_err, and enter RESP with rdata 32'hFFFFFFFF.
REQ-026 Under GEN_ARB4RR_TIMEOUT_EN, dev_ack arriving in the same cycle as the timeout SHALL win.
REQ-027 Without the macro, SHALL contain no counter, SHALL tie to_err to 0, and SHALL leave GRANT waiting indefinitely.

Structure
REQ-028 SHALL use package gen_arb4rr_pkg for the state encoding typedef, ARB_NPORT=4 and RDATA_TIMEOUT=32'hFFFFFFFF.
REQ-029 SHALL use one sub-module, gen_rr_pick4: combinational 4-way round-robin picker (req[3:0], last[1:0] -> grant index, valid).

Verification
REQ-030 After reset, p0 reads 0x100 and the device acks after 3 cycles with 0xA5A5A5A5 -> dev_addr=0x100, p0_ack one cycle, p0_rdata=0xA5A5A5A5.
REQ-031 All four req held continuously, each ack followed by one low cycle then re-raised -> grant order 0,1,2,3,0; no port starved.
REQ-032 p2 is granted, then p1 asserts req -> p1 served only after p2_req drops; dev_addr stays stable throughout p2's GRANT.
REQ-033 Reset pulse while in GRANT -> dev_req=0 immediately, no pN_ack, next grant is port 0.
REQ-034 With the macro and TO_CYCLES=4, no dev_ack -> to_err pulse, p0_ack with p0_rdata=0xFFFFFFFF, 6 cycles after p0_req.
REQ-035 Write from p3 (wr=1, be=4'b0011, wdata=0x12345678) -> dev_wr=1, dev_be=0x3 and dev_wdata match, p3_ack one cycle.
